coax_frame_tx: RTL and testbench
================================

// Module: coax_frame_tx
// PURPOSE
//  FIFO-buffered coax transmitter that queues multiple frames.
//  Each loaded word carries an end-of-frame flag; one start sends one frame.
//  Adds an auto-start mode and an abort/flush. Wraps coax_tx (bit serialiser)
//  and a DEPTH x 11 sync FIFO. Sits between the host register interface and the line driver.
// PARAMETERS
//  CLOCKS_PER_BIT  8    clk cycles per coax bit, passed to coax_tx
//  DEPTH           256  FIFO words, power of 2, >= 4
//  AUTO_START      0    1: send whenever a complete frame is queued; 0: wait for start_strobe
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high
//  data          in   10  coax word to queue
//  last          in   1   data is the final word of its frame
//  load_strobe   in   1   push {last,data}
//  start_strobe  in   1   send the oldest complete frame
//  abort_strobe  in   1   stop sending and flush the FIFO
//  active        out  1   line active (from coax_tx)
//  tx            out  1   serial line (from coax_tx)
//  empty         out  1   FIFO empty
//  full          out  1   FIFO full
//  level         out  AW+1  words queued, AW=$clog2(DEPTH)
//  frames        out  AW+1  complete frames queued (last=1 words in FIFO)
//  ready         out  1   low in DRAIN/ABORT
//  done_strobe   out  1   1-cycle pulse when a frame has left the line
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO flushed, empty=1, full=0, level=0, frames=0,
//   ready=1, done_strobe=0, coax strobe=0.
//  FSM states IDLE, SEND, POP, DRAIN, ABORT. Internal strobes are registered from next-state logic.
//  IDLE: (start_strobe || AUTO_START) && frames!=0 -> SEND. Otherwise stay.
//   A start with frames==0 is dropped and is not remembered.
//  SEND: when coax_tx ready, assert coax strobe next cycle with the FIFO head, then -> POP.
//  POP: pop head (1 cycle); head.last ? -> DRAIN : -> SEND.
//  DRAIN: wait for !active, then pulse done_strobe for 1 cycle, then -> IDLE.
//   The next frame needs a new start (auto mode restarts the cycle after returning to IDLE).
//  Latency: start at cycle N -> SEND at N+1 -> coax strobe at N+2 if coax_tx is ready.
//  Underrun is impossible: SEND is entered only with a complete frame queued.
//  Load with full=1: ignored; level and frames are unchanged.
//  Load and pop in the same cycle: both take effect; level is unchanged.
//   frames changes by (+1 if pushed last) and (-1 if popped last).
//  Pointers wrap modulo DEPTH. level==DEPTH <=> full; level==0 <=> empty.
//  abort_strobe, in any state: FIFO flushed that cycle (level=frames=0); a load in the same cycle is dropped.
//   No further coax strobes. The word already inside coax_tx completes.
//   Non-IDLE -> ABORT, then IDLE once !active. No done_strobe. In IDLE, abort only flushes.
//  ready = (next_state != DRAIN && next_state != ABORT).
//  Reset mid-frame: line released immediately via coax_tx reset; queued data is lost.
// TESTING
//  1. Load 0x155,0x2AA(last), then start -> both words on tx in order;
//     done_strobe once after active falls; level 2->0, frames 1->0.
//  2. Queue frame A (3 words) and frame B (2 words), then one start -> only A is sent; frames=1.
//     Second start -> B is sent.
//  3. AUTO_START=1: load 2 words with last on the 2nd -> sending begins 2 cycles later
//     with no start_strobe.
//  4. Fill DEPTH=4 (full=1), then a 5th load -> ignored, level=4.
//     Load and pop in the same cycle -> level constant.
//  5. Abort during word 2 of a 4-word frame -> word 2 finishes, words 3-4 never sent;
//     level=0, ready=0 until !active, no done_strobe.
//  6. Start with only an unterminated frame queued (frames=0) -> stays IDLE, tx idle.

Source files
------------

// File: rtl/coax_frame_tx.sv
// coax_frame_tx: frame-queuing coax transmitter.
// Host pushes {last,data} words into a DEPTH x 11 FIFO; a start (or auto mode)
// sends the oldest complete frame word by word through coax_tx, then pulses
// done_strobe once the line goes quiet. abort_strobe flushes the queue.
//
// Line format produced by coax_tx: the line idles low. Each word is 11 bit
// times of CLOCKS_PER_BIT cycles: a '1' sync bit, then data[9:0] MSB first.
// active is high for exactly those 11 bit times.
//
// Handshake: coax_tx accepts a word on a cycle where strobe=1 and ready=1;
// ready is low for the whole time a word is on the line, and a strobe while
// not ready is ignored. Host strobes are single-cycle requests with no
// back-pressure; a load is taken only when full=0 and abort_strobe=0.

module coax_tx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       strobe,
  output logic       ready,
  output logic       active,
  output logic       tx
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // Next-state for the serialiser: load when idle, else step bit timing.
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (!busy_q) begin
      if (strobe) begin
        shift_d = {1'b1, data};
        bit_d   = 4'd0;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    end else if (cnt_q == CW'(CLOCKS_PER_BIT - 1)) begin
      cnt_d   = '0;
      shift_d = {shift_q[9:0], 1'b0};
      if (bit_q == 4'd10) begin
        busy_d = 1'b0;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Serialiser registers; reset releases the line immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign ready  = !busy_q;
  assign active = busy_q;
  assign tx     = busy_q & shift_q[10];

endmodule

module coax_frame_tx #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DEPTH          = 256,
  parameter int AUTO_START     = 0,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  data,
  input  logic        last,
  input  logic        load_strobe,
  input  logic        start_strobe,
  input  logic        abort_strobe,
  output logic        active,
  output logic        tx,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level,
  output logic [AW:0] frames,
  output logic        ready,
  output logic        done_strobe,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_POP   = 3'd2,
    S_DRAIN = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  // ---------------- FIFO ----------------
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [AW:0]   frames_q, frames_d;
  logic [10:0]   head;
  logic          push, pop;

  state_t state_q, state_d;

  assign head  = mem[rd_ptr_q];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level  = level_q;
  assign frames = frames_q;

  // Abort owns the cycle: it drops any load and cancels any pop.
  assign push = load_strobe && !full && !abort_strobe;
  assign pop  = (state_q == S_POP) && !abort_strobe;

  // FIFO pointer, level and complete-frame bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    frames_d = frames_q;
    if (abort_strobe) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      frames_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      case ({push && last, pop && head[10]})
        2'b10:   frames_d = frames_q + (AW+1)'(1);
        2'b01:   frames_d = frames_q - (AW+1)'(1);
        default: frames_d = frames_q;
      endcase
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      frames_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      frames_q <= frames_d;
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {last, data};
  end

  // ---------------- Sequencer ----------------
  logic       coax_strobe_q, coax_strobe_d;
  logic [9:0] coax_data_q, coax_data_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic       coax_ready, coax_active;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d       = state_q;
    coax_strobe_d = 1'b0;
    coax_data_d   = coax_data_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((start_strobe || (AUTO_START != 0)) && (frames_q != '0)) state_d = S_SEND;
      end
      S_SEND: begin
        if (coax_ready) begin
          coax_strobe_d = 1'b1;
          coax_data_d   = head[9:0];
          state_d       = S_POP;
        end
      end
      S_POP: begin
        state_d = head[10] ? S_DRAIN : S_SEND;
      end
      S_DRAIN: begin
        if (!coax_active) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (!coax_active) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_strobe) begin
      coax_strobe_d = 1'b0;
      done_d        = 1'b0;
      state_d       = (state_q == S_IDLE) ? S_IDLE : S_ABORT;
    end
    ready_d = (state_d != S_DRAIN) && (state_d != S_ABORT);
  end

  // Sequencer state and its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      coax_strobe_q <= 1'b0;
      coax_data_q   <= '0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      coax_strobe_q <= coax_strobe_d;
      coax_data_q   <= coax_data_d;
      done_q        <= done_d;
      ready_q       <= ready_d;
    end
  end

  assign ready       = ready_q;
  assign done_strobe = done_q;
  assign state_dbg   = state_q;

  coax_tx #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_coax_tx (
    .clk    (clk),
    .reset  (reset),
    .data   (coax_data_q),
    .strobe (coax_strobe_q),
    .ready  (coax_ready),
    .active (coax_active),
    .tx     (tx)
  );

  assign active = coax_active;

endmodule

// File: tb/tb_coax_frame_tx.sv
// Directed bench for coax_frame_tx: a manual-start instance (DEPTH=8) and an
// auto-start instance (DEPTH=4), a line decoder, and one task per scenario.
module tb_coax_frame_tx;

  localparam int CPB = 4;
  localparam int DEPTH = 8;
  localparam int A_DEPTH = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_SEND = 3'd1, ST_POP = 3'd2, ST_ABORT = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // manual-start instance
  logic [9:0] data;
  logic       last, load_strobe, start_strobe, abort_strobe;
  logic       active, tx, empty, full, ready, done_strobe;
  logic [3:0] level, frames;
  logic [2:0] state_dbg;

  // auto-start instance
  logic [9:0] a_data;
  logic       a_last, a_load, a_abort;
  logic       a_active, a_tx, a_empty, a_full, a_ready, a_done;
  logic [2:0] a_level, a_frames;
  logic [2:0] a_state;

  int tests_run = 0;
  int tests_failed = 0;

  coax_frame_tx #(.CLOCKS_PER_BIT(CPB), .DEPTH(DEPTH), .AUTO_START(0)) dut (
    .clk(clk), .reset(reset), .data(data), .last(last), .load_strobe(load_strobe),
    .start_strobe(start_strobe), .abort_strobe(abort_strobe), .active(active), .tx(tx),
    .empty(empty), .full(full), .level(level), .frames(frames), .ready(ready),
    .done_strobe(done_strobe), .state_dbg(state_dbg)
  );

  coax_frame_tx #(.CLOCKS_PER_BIT(CPB), .DEPTH(A_DEPTH), .AUTO_START(1)) dut_auto (
    .clk(clk), .reset(reset), .data(a_data), .last(a_last), .load_strobe(a_load),
    .start_strobe(1'b0), .abort_strobe(a_abort), .active(a_active), .tx(a_tx),
    .empty(a_empty), .full(a_full), .level(a_level), .frames(a_frames), .ready(a_ready),
    .done_strobe(a_done), .state_dbg(a_state)
  );

  // ---------------- line decoder / event counters ----------------
  logic [10:0] rx_q[$];
  int done_cnt = 0;
  int a_done_cnt = 0;

  initial begin : rx_mon
    logic [10:0] w;
    forever begin
      @(negedge clk);
      if (active && !reset) begin
        w = '0;
        repeat (CPB / 2) @(negedge clk);
        w = {w[9:0], tx};
        for (int b = 1; b < 11; b++) begin
          repeat (CPB) @(negedge clk);
          w = {w[9:0], tx};
        end
        rx_q.push_back(w);
        while (active) @(negedge clk);
      end
    end
  end

  always @(negedge clk) begin
    if (done_strobe) done_cnt++;
    if (a_done) a_done_cnt++;
  end

  // ---------------- driver tasks (entered just after a negedge) ----------------
  task automatic load_word(input logic [9:0] d, input logic l);
    data = d; last = l; load_strobe = 1'b1;
    @(negedge clk);
    load_strobe = 1'b0;
  endtask

  task automatic a_load_word(input logic [9:0] d, input logic l);
    a_data = d; a_last = l; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
  endtask

  task automatic pulse_start();
    start_strobe = 1'b1;
    @(negedge clk);
    start_strobe = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_strobe = 1'b1;
    @(negedge clk);
    abort_strobe = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done_strobe) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({empty, full, level, frames, ready, done_strobe, active, tx, state_dbg} !==
        {1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got e%b f%b lvl%0d fr%0d rdy%b done%b act%b tx%b st%0d, expected e1 f0 lvl0 fr0 rdy1 done0 act0 tx0 st0",
               empty, full, level, frames, ready, done_strobe, active, tx, state_dbg);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({a_empty, a_full, a_level, a_frames, a_ready, a_state} !== {1'b1, 1'b0, 3'd0, 3'd0, 1'b1, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL reset_auto: got e%b f%b lvl%0d fr%0d rdy%b st%0d, expected e1 f0 lvl0 fr0 rdy1 st0",
               a_empty, a_full, a_level, a_frames, a_ready, a_state);
    end
  endtask

  task automatic test_single_frame();
    int base = rx_q.size();
    int d0 = done_cnt;
    bit ok;
    load_word(10'h155, 1'b0);
    load_word(10'h2AA, 1'b1);
    tests_run++;
    if ({level, frames, state_dbg} !== {4'd2, 4'd1, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL single_queued: got lvl%0d fr%0d st%0d, expected lvl2 fr1 st0", level, frames, state_dbg);
    end
    pulse_start();
    tests_run++;
    if (state_dbg !== ST_SEND) begin
      tests_failed++;
      $display("FAIL single_lat_send: got st%0d, expected st1", state_dbg);
    end
    @(negedge clk);
    tests_run++;
    if ({state_dbg, active} !== {ST_POP, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_lat_pop: got st%0d act%b, expected st2 act0", state_dbg, active);
    end
    @(negedge clk);
    tests_run++;
    if ({active, tx, level} !== {1'b1, 1'b1, 4'd1}) begin
      tests_failed++;
      $display("FAIL single_line_start: got act%b tx%b lvl%0d, expected act1 tx1 lvl1", active, tx, level);
    end
    wait_done(400, ok);
    tests_run++;
    if ({ok, active, level, frames} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL single_done: got seen%b act%b lvl%0d fr%0d, expected seen1 act0 lvl0 fr0", ok, active, level, frames);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (rx_q.size() != base + 2 || rx_q[base] !== 11'h555 || rx_q[base+1] !== 11'h6AA) begin
      tests_failed++;
      $display("FAIL single_words: got %0d words, expected 2 words 555 6aa", rx_q.size() - base);
    end
    tests_run++;
    if (done_cnt - d0 != 1) begin
      tests_failed++;
      $display("FAIL single_done_count: got %0d pulses, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_two_frames();
    int base = rx_q.size();
    bit ok;
    load_word(10'h101, 1'b0);
    load_word(10'h0F0, 1'b0);
    load_word(10'h3C3, 1'b1);
    load_word(10'h211, 1'b0);
    load_word(10'h08E, 1'b1);
    tests_run++;
    if ({level, frames} !== {4'd5, 4'd2}) begin
      tests_failed++;
      $display("FAIL two_queued: got lvl%0d fr%0d, expected lvl5 fr2", level, frames);
    end
    pulse_start();
    wait_done(800, ok);
    repeat (20) @(negedge clk);
    tests_run++;
    if ({ok, level, frames, state_dbg, active} !== {1'b1, 4'd2, 4'd1, ST_IDLE, 1'b0}) begin
      tests_failed++;
      $display("FAIL two_first_frame: got seen%b lvl%0d fr%0d st%0d act%b, expected seen1 lvl2 fr1 st0 act0",
               ok, level, frames, state_dbg, active);
    end
    tests_run++;
    if (rx_q.size() != base + 3 || rx_q[base] !== 11'h501 || rx_q[base+1] !== 11'h4F0 ||
        rx_q[base+2] !== 11'h7C3) begin
      tests_failed++;
      $display("FAIL two_frame_a_words: got %0d words, expected 3 words 501 4f0 7c3", rx_q.size() - base);
    end
    pulse_start();
    wait_done(800, ok);
    repeat (20) @(negedge clk);
    tests_run++;
    if ({ok, level, frames, empty} !== {1'b1, 4'd0, 4'd0, 1'b1} || rx_q.size() != base + 5 ||
        rx_q[base+3] !== 11'h611 || rx_q[base+4] !== 11'h48E) begin
      tests_failed++;
      $display("FAIL two_frame_b: got seen%b lvl%0d fr%0d words%0d, expected seen1 lvl0 fr0 words5 (611 48e)",
               ok, level, frames, rx_q.size() - base);
    end
  endtask

  task automatic test_auto_start();
    int d0 = a_done_cnt;
    bit ok = 1'b0;
    a_load_word(10'h0AA, 1'b0);
    tests_run++;
    if ({a_frames, a_state} !== {3'd0, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL auto_partial: got fr%0d st%0d, expected fr0 st0", a_frames, a_state);
    end
    a_load_word(10'h1F0, 1'b1);
    tests_run++;
    if ({a_frames, a_level, a_state} !== {3'd1, 3'd2, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL auto_queued: got fr%0d lvl%0d st%0d, expected fr1 lvl2 st0", a_frames, a_level, a_state);
    end
    @(negedge clk);
    tests_run++;
    if (a_state !== ST_SEND) begin
      tests_failed++;
      $display("FAIL auto_send: got st%0d, expected st1", a_state);
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if ({a_active, a_tx} !== 2'b11) begin
      tests_failed++;
      $display("FAIL auto_line: got act%b tx%b, expected act1 tx1", a_active, a_tx);
    end
    for (int i = 0; i < 400; i++) begin
      if (a_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if ({ok, a_level, a_frames, a_state, a_active} !== {1'b1, 3'd0, 3'd0, ST_IDLE, 1'b0} ||
        a_done_cnt - d0 != 1) begin
      tests_failed++;
      $display("FAIL auto_done: got seen%b lvl%0d fr%0d st%0d act%b pulses%0d, expected seen1 lvl0 fr0 st0 act0 pulses1",
               ok, a_level, a_frames, a_state, a_active, a_done_cnt - d0);
    end
  endtask

  task automatic test_full_and_overlap();
    bit found = 1'b0;
    for (int i = 0; i < 7; i++) load_word(10'(i + 16), 1'b0);
    load_word(10'h077, 1'b1);
    tests_run++;
    if ({full, empty, level, frames} !== {1'b1, 1'b0, 4'd8, 4'd1}) begin
      tests_failed++;
      $display("FAIL full_fill: got f%b e%b lvl%0d fr%0d, expected f1 e0 lvl8 fr1", full, empty, level, frames);
    end
    load_word(10'h3FF, 1'b1);
    tests_run++;
    if ({full, level, frames} !== {1'b1, 4'd8, 4'd1}) begin
      tests_failed++;
      $display("FAIL full_drop: got f%b lvl%0d fr%0d, expected f1 lvl8 fr1", full, level, frames);
    end
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      if (state_dbg == ST_POP && level == 4'd7) begin found = 1'b1; break; end
      @(negedge clk);
    end
    load_word(10'h3FE, 1'b1);
    tests_run++;
    if ({found, level, frames} !== {1'b1, 4'd7, 4'd2}) begin
      tests_failed++;
      $display("FAIL full_push_pop: got found%b lvl%0d fr%0d, expected found1 lvl7 fr2", found, level, frames);
    end
    pulse_abort();
    tests_run++;
    if ({level, frames, empty, full, ready, state_dbg} !== {4'd0, 4'd0, 1'b1, 1'b0, 1'b0, ST_ABORT}) begin
      tests_failed++;
      $display("FAIL full_flush: got lvl%0d fr%0d e%b f%b rdy%b st%0d, expected lvl0 fr0 e1 f0 rdy0 st4",
               level, frames, empty, full, ready, state_dbg);
    end
    for (int i = 0; i < 200 && state_dbg != ST_IDLE; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    int base = rx_q.size();
    int d0 = done_cnt;
    bit found = 1'b0;
    load_word(10'h011, 1'b0);
    load_word(10'h022, 1'b0);
    load_word(10'h033, 1'b0);
    load_word(10'h044, 1'b1);
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      if (rx_q.size() == base + 1 && active) begin found = 1'b1; break; end
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    pulse_abort();
    tests_run++;
    if ({found, level, frames, ready, active, state_dbg} !== {1'b1, 4'd0, 4'd0, 1'b0, 1'b1, ST_ABORT}) begin
      tests_failed++;
      $display("FAIL abort_entry: got found%b lvl%0d fr%0d rdy%b act%b st%0d, expected found1 lvl0 fr0 rdy0 act1 st4",
               found, level, frames, ready, active, state_dbg);
    end
    for (int i = 0; i < 200 && active; i++) @(negedge clk);
    tests_run++;
    if ({active, ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_ready_hold: got act%b rdy%b, expected act0 rdy0", active, ready);
    end
    @(negedge clk);
    tests_run++;
    if ({ready, state_dbg} !== {1'b1, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL abort_release: got rdy%b st%0d, expected rdy1 st0", ready, state_dbg);
    end
    repeat (150) @(negedge clk);
    tests_run++;
    if (rx_q.size() != base + 2 || rx_q[base] !== 11'h411 || rx_q[base+1] !== 11'h422 ||
        done_cnt != d0 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_words: got words%0d pulses%0d act%b, expected words2 (411 422) pulses0 act0",
               rx_q.size() - base, done_cnt - d0, active);
    end
  endtask

  task automatic test_start_without_frame();
    load_word(10'h155, 1'b0);
    pulse_start();
    tests_run++;
    if ({state_dbg, level, frames} !== {ST_IDLE, 4'd1, 4'd0}) begin
      tests_failed++;
      $display("FAIL nostart_idle: got st%0d lvl%0d fr%0d, expected st0 lvl1 fr0", state_dbg, level, frames);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if ({state_dbg, active, tx} !== {ST_IDLE, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL nostart_line: got st%0d act%b tx%b, expected st0 act0 tx0", state_dbg, active, tx);
    end
    pulse_abort();
    tests_run++;
    if ({level, empty, ready, state_dbg} !== {4'd0, 1'b1, 1'b1, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL idle_abort: got lvl%0d e%b rdy%b st%0d, expected lvl0 e1 rdy1 st0", level, empty, ready, state_dbg);
    end
  endtask

  task automatic test_reset_mid_frame();
    load_word(10'h3FF, 1'b0);
    load_word(10'h3FF, 1'b1);
    pulse_start();
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({active, tx, level, frames, state_dbg} !== {1'b0, 1'b0, 4'd0, 4'd0, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL reset_mid: got act%b tx%b lvl%0d fr%0d st%0d, expected act0 tx0 lvl0 fr0 st0",
               active, tx, level, frames, state_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    data = '0; last = 1'b0; load_strobe = 1'b0; start_strobe = 1'b0; abort_strobe = 1'b0;
    a_data = '0; a_last = 1'b0; a_load = 1'b0; a_abort = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_two_frames();
    test_auto_start();
    test_full_and_overlap();
    test_abort();
    test_start_without_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
